uart_rx_fifo: RTL and testbench

Memory-mapped UART receive unit that sits directly upstream of the CPU's peripheral read path. It deserialises 8N1 frames from the `rx` pin, buffers received bytes in a small FIFO, and presents data and status to CPU loads. It also drives a level interrupt request toward the CPU's IRQ input. The block runs entirely on `sysclk`. The CPU's divided clock only shapes the strobes it sees.

---
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO behind a memory-mapped register window.
// The synchronizer, receiver FSM, FIFO, status flags and irq all run on sysclk.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic        rx,
   input  logic        rd,
   input  logic        wr,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rx_state_t;

   rx_state_t      state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2:0]     idx, idx_n;
   logic [7:0]     shreg, shreg_n;
   logic           stop_ok, frame_set;
   logic           rx_meta, rx_s;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wptr, rptr;
   logic [AW:0]    count;
   logic           rd_q, wr_q;
   logic           overrun, frame_err, rx_ie;
   logic           nonempty, full, pop, push, accept, overrun_set;
   logic           status_wr, ctrl_wr;
   logic           unused_wdata;

   assign unused_wdata = ^wdata[31:3];

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
      end
   end

   // Start is checked mid-bit; data and stop bits are sampled a full bit period apart.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      idx_n     = idx;
      shreg_n   = shreg;
      stop_ok   = 1'b0;
      frame_set = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF_CNT) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == LAST_CNT) begin
               shreg_n = {rx_s, shreg[7:1]};
               cnt_n   = '0;
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (cnt == LAST_CNT) begin
               cnt_n = '0;
               if (rx_s) begin
                  stop_ok = 1'b1;
                  state_n = IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_n   = WAITHI;
               end
            end
         end
         WAITHI: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign nonempty    = (count != '0);
   assign full        = (count == DEPTH_CNT);
   assign pop         = rd & ~rd_q & (addr == 4'h0) & nonempty;
   // A same-edge pop frees a slot, so a full FIFO can still take the byte.
   assign accept      = ~full | pop;
   assign push        = stop_ok & accept;
   assign overrun_set = stop_ok & ~accept;
   assign status_wr   = wr & ~wr_q & (addr == 4'h4);
   assign ctrl_wr     = wr & ~wr_q & (addr == 4'h8);

   always_ff @(posedge sysclk) begin
      if (push) mem[wptr] <= shreg;
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         rx_ie     <= 1'b0;
         irq       <= 1'b0;
      end else begin
         rd_q <= rd;
         wr_q <= wr;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         overrun   <= overrun_set | (overrun & ~(status_wr & wdata[2]));
         frame_err <= frame_set | (frame_err & ~(status_wr & wdata[1]));
         if (ctrl_wr) rx_ie <= wdata[0];
         irq <= rx_ie & (nonempty | overrun | frame_err);
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         4'h0: if (nonempty) rdata = {24'd0, mem[rptr]};
         4'h4: rdata = {27'd0, full, overrun, frame_err, full, nonempty};
         4'h8: rdata = {31'd0, rx_ie};
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked against a queue-based model
// of the byte stream, the sticky error flags and the interrupt enable.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic        sysclk = 1'b0;
   logic        reset  = 1'b1;
   logic        rx     = 1'b1;
   logic        rd     = 1'b0;
   logic        wr     = 1'b0;
   logic [3:0]  addr   = 4'h4;
   logic [31:0] wdata  = '0;
   logic [31:0] rdata;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] q [$];
   logic       ovr_m = 1'b0;
   logic       fe_m  = 1'b0;
   logic       ie_m  = 1'b0;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .sysclk(sysclk), .reset(reset), .rx(rx), .rd(rd), .wr(wr),
      .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [31:0] exp_status();
      logic f;
      f = (q.size() == DEPTH);
      return {27'd0, f, ovr_m, fe_m, f, (q.size() != 0)};
   endfunction

   function automatic logic exp_irq();
      return ie_m & ((q.size() != 0) | ovr_m | fe_m);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A correctly stopped frame lands in the queue unless the queue is already full.
   task automatic model_frame(input logic [7:0] b);
      if (q.size() < DEPTH) q.push_back(b);
      else ovr_m = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   // Called just after a rising edge; optional pop lands on the stop-sample edge (E0+155).
   task automatic apply_stimulus(input logic [7:0] b, input int stop_low, input int gap, input bit pop_at_stop);
      logic [9:0] bits;
      int n;
      bits = {1'b1, b, 1'b0};
      n = 0;
      for (int i = 0; i < 10; i++) begin
         rx = (i == 9 && stop_low > 0) ? 1'b0 : bits[i];
         for (int c = 0; c < CPB; c++) begin
            @(posedge sysclk);
            #1;
            n++;
            if (pop_at_stop && n == 154) begin
               addr = 4'h0;
               rd   = 1'b1;
            end
            if (pop_at_stop && n == 156) begin
               rd   = 1'b0;
               addr = 4'h4;
            end
         end
      end
      if (stop_low > 1) tick((stop_low - 1) * CPB);
      rx = 1'b1;
      tick(gap);
   endtask

   task automatic read_status(input string tag);
      addr = 4'h4;
      #1;
      check_output(tag, rdata, exp_status());
      tick(1);
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] exp;
      exp = (q.size() != 0) ? {24'd0, q[0]} : 32'd0;
      addr = 4'h0;
      #1;
      check_output(tag, rdata, exp);
      rd = 1'b1;
      tick(3);
      rd = 1'b0;
      addr = 4'h4;
      tick(1);
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      tick(3);
      wr    = 1'b0;
      addr  = 4'h4;
      tick(1);
   endtask

   initial begin
      logic [7:0] b;
      int n;

      // Reset state
      tick(3);
      check_output("rst_status", rdata, 32'd0);
      check_output("rst_irq", {31'd0, irq}, 32'd0);
      addr = 4'h0;
      #1;
      check_output("rst_rxdata", rdata, 32'd0);
      addr = 4'h4;
      tick(1);
      reset = 1'b0;
      tick(2);

      // Single byte
      apply_stimulus(8'hA5, 0, 4, 1'b0);
      model_frame(8'hA5);
      read_status("single_status");
      pop_check("single_data");
      read_status("single_empty");

      // Fill, overrun, drain, clear
      for (int i = 1; i <= 5; i++) begin
         apply_stimulus(8'(i), 0, 0, 1'b0);
         model_frame(8'(i));
      end
      tick(2);
      read_status("ovr_status");
      for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
      read_status("ovr_drained");
      bus_write(4'h4, 32'h4);
      ovr_m = 1'b0;
      read_status("ovr_cleared");

      // Framing error then recovery
      apply_stimulus(8'h3C, 3, 8, 1'b0);
      fe_m = 1'b1;
      read_status("fe_status");
      apply_stimulus(8'h7E, 0, 4, 1'b0);
      model_frame(8'h7E);
      pop_check("fe_next_frame");
      bus_write(4'h4, 32'h2);
      fe_m = 1'b0;
      read_status("fe_cleared");

      // Short low pulse must be ignored
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(40);
      read_status("glitch_status");
      pop_check("glitch_empty");

      // Interrupt enable and pop coinciding with a full-FIFO push
      bus_write(4'h8, 32'hFFFF_FFFF);
      ie_m = 1'b1;
      addr = 4'h8;
      #1;
      check_output("ctrl_read", rdata, 32'd1);
      check_output("irq_idle", {31'd0, irq}, {31'd0, exp_irq()});
      addr = 4'h4;
      tick(1);
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         apply_stimulus(b, 0, 1, 1'b0);
         model_frame(b);
      end
      check_output("irq_full", {31'd0, irq}, {31'd0, exp_irq()});
      addr = 4'h0;
      #1;
      check_output("simul_head", rdata, {24'd0, q[0]});
      addr = 4'h4;
      b = 8'($urandom);
      apply_stimulus(b, 0, 2, 1'b1);
      void'(q.pop_front());
      q.push_back(b);
      read_status("simul_status");
      for (int i = 0; i < DEPTH - 1; i++) pop_check("simul_drain");
      addr = 4'h0;
      #1;
      check_output("last_pop_data", rdata, {24'd0, q[0]});
      rd = 1'b1;
      tick(1);
      void'(q.pop_front());
      check_output("irq_after_pop", {31'd0, irq}, 32'd1);
      tick(1);
      check_output("irq_fall", {31'd0, irq}, {31'd0, exp_irq()});
      rd = 1'b0;
      addr = 4'h4;
      tick(1);
      read_status("drain_status");

      // Random bursts with random inter-frame gaps
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            apply_stimulus(b, 0, int'($urandom_range(0, 3)), 1'b0);
            model_frame(b);
         end
         tick(1);
         read_status("rand_status");
         check_output("rand_irq", {31'd0, irq}, {31'd0, exp_irq()});
         while (q.size() != 0) pop_check("rand_pop");
         read_status("rand_drained");
         bus_write(4'h4, 32'h6);
         ovr_m = 1'b0;
      end

      // Reset during data bit 4
      apply_stimulus(8'h11, 0, 2, 1'b0);
      model_frame(8'h11);
      check_output("pre_rst_irq", {31'd0, irq}, {31'd0, exp_irq()});
      b = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         rx = (i == 0) ? 1'b0 : b[i-1];
         tick(CPB);
      end
      rx = b[4];
      tick(CPB / 2);
      reset = 1'b1;
      #1;
      q.delete();
      ovr_m = 1'b0;
      fe_m  = 1'b0;
      ie_m  = 1'b0;
      check_output("midrst_irq", {31'd0, irq}, 32'd0);
      check_output("midrst_status", rdata, exp_status());
      addr = 4'h0;
      #1;
      check_output("midrst_rxdata", rdata, 32'd0);
      addr = 4'h8;
      #1;
      check_output("midrst_ctrl", rdata, 32'd0);
      addr = 4'h4;
      rx = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      apply_stimulus(8'h5A, 0, 4, 1'b0);
      model_frame(8'h5A);
      read_status("post_rst_status");
      pop_check("post_rst_data");
      read_status("post_rst_empty");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
